// File: rtl/pipe_stage_elastic.sv
// Elastic register chain of DEPTH valid/ready stages with bubble collapsing, synchronous flush and occupancy count.
// Defining PIPE_STAGE_SKID_EN adds a one-entry input skid so in_ready_o becomes a pure flop output.
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             rdy;
    logic                         rdy_acc;
    logic [DEPTH-1:0]             src_valid;
    logic [DEPTH-1:0][DATA_W-1:0] src_data;
    logic                         head_valid;
    logic [DATA_W-1:0]            head_data;
    logic                         in_hs;
    logic                         out_hs;
    logic [CNT_W-1:0]             count_q;

    // An empty stage is always ready, so bubbles collapse even under a downstream stall.
    always_comb begin
        rdy_acc = out_ready_i;
        rdy     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_acc = !valid_q[k] || rdy_acc;
            rdy[k]  = rdy_acc;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_data     = '0;
        src_valid[0] = head_valid;
        src_data[0]  = head_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    // The skid has priority into stage 0; while it is occupied no new input is accepted.
    assign head_valid = skid_valid || in_valid_i;
    assign head_data  = skid_valid ? skid_data : in_data_i;
    assign in_ready_o = !skid_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush_i) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (rdy[0]) begin
                skid_valid <= 1'b0;
            end
        end else if (in_valid_i && !rdy[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data_i;
        end
    end
`else
    assign head_valid = in_valid_i;
    assign head_data  = in_data_i;
    assign in_ready_o = rdy[0];
`endif

    // Data is only overwritten by a valid source, so idle stages keep their last payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= src_data[k];
                    end
                end
            end
        end
    end

    assign in_hs  = in_valid_i && in_ready_o;
    assign out_hs = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            unique case ({in_hs, out_hs})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: table-driven stall/flush vectors, streaming, async reset, optional skid.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;
    localparam int DW  = 32;
    localparam int DEP = 3;
    localparam int CW  = $clog2(DEP + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    pipe_stage_elastic #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ready_i(out_ready), .flush_i(flush), .count_o(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        int            acc;
        bit            chk;
    } item_t;
    item_t sb[$];

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          irdy;
        logic          ov;
        logic [DW-1:0] od;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                                input logic irdy, input logic ov, input logic [DW-1:0] od, input logic [CW-1:0] cnt);
        return '{iv, d, ordy, fl, irdy, ov, od, cnt};
    endfunction

    // Called at posedge+1: drive, check combinational ready, cross one edge, check registered outputs.
    task automatic row(input vec_t v, input string tag);
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        flush     = v.fl;
        #1;
        chk($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(v.irdy));
        @(posedge clk);
        #1;
        chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(v.ov));
        chk($sformatf("%s.out_data", tag), out_data, v.od);
        chk($sformatf("%s.count", tag), 32'(count), 32'(v.cnt));
    endtask

    always @(posedge clk) edge_n++;

    always @(posedge rst) sb.delete();

    // Scoreboard: handshakes commit at the next rising edge; inputs are stable from posedge+1 onwards.
    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_out: got %h expected no output", out_data);
                end else begin
                    it = sb.pop_front();
                    chk("sb_out_data", out_data, it.d);
                    if (it.chk) chk("sb_latency", 32'(edge_n + 1 - it.acc), 32'(DEP));
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back('{in_data, edge_n + 1, lat_chk});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

`ifdef PIPE_STAGE_SKID_EN
    logic          s_in_valid = 1'b0;
    logic [DW-1:0] s_in_data = '0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic          s_out_ready = 1'b0;
    logic [1:0]    s_count;

    pipe_stage_elastic #(.DATA_W(DW), .DEPTH(1)) u_skid (
        .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_data_i(s_in_data),
        .in_ready_o(s_in_ready), .out_valid_o(s_out_valid), .out_data_o(s_out_data),
        .out_ready_i(s_out_ready), .flush_i(1'b0), .count_o(s_count)
    );
`endif

    initial begin
        tbl.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  3'd1));
        tbl.push_back(mk(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  3'd2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3'd2));
        tbl.push_back(mk(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3'd3));
        tbl.push_back(mk(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd3));
        tbl.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 3'd3));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 3'd2));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 3'd1));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 3'd0));
        tbl.push_back(mk(1'b1, 32'h51, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 3'd1));
        tbl.push_back(mk(1'b1, 32'h52, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 3'd2));
        tbl.push_back(mk(1'b1, 32'h53, 1'b0, 1'b0, 1'b1, 1'b1, 32'h51, 3'd3));
        tbl.push_back(mk(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 32'h52, 3'd3));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h53, 3'd2));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 3'd1));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 3'd0));
        tbl.push_back(mk(1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 3'd1));
        tbl.push_back(mk(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 3'd2));
        tbl.push_back(mk(1'b1, 32'h88, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 3'd0));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 3'd0));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 3'd0));
        tbl.push_back(mk(1'b1, 32'h91, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 3'd1));
        tbl.push_back(mk(1'b1, 32'h92, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 3'd2));
        tbl.push_back(mk(1'b1, 32'h93, 1'b0, 1'b0, 1'b1, 1'b1, 32'h91, 3'd3));
        tbl.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h91, 3'd0));

        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data", out_data, 32'd0);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) row(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back stream with the sink always ready.
        lat_chk = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            int acc;
            int outs;
            in_valid  = (e <= 5);
            in_data   = 32'hA000_0001 + 32'(e - 1);
            out_ready = 1'b1;
            flush     = 1'b0;
            #1;
            chk($sformatf("stream%0d.in_ready", e), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            acc  = (e < 5) ? e : 5;
            outs = (e - 3 < 0) ? 0 : ((e - 3 > 5) ? 5 : e - 3);
            chk($sformatf("stream%0d.count", e), 32'(count), 32'(acc - outs));
            chk($sformatf("stream%0d.out_valid", e), 32'(out_valid), 32'(e >= 3 && e <= 7));
            if (e >= 3 && e <= 7)
                chk($sformatf("stream%0d.out_data", e), out_data, 32'hA000_0001 + 32'(e - 3));
        end
        lat_chk = 1'b0;

        row(mk(1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0005, 3'd1), "rst_a");
        row(mk(1'b1, 32'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0005, 3'd2), "rst_b");
        row(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hC1, 3'd2), "rst_c");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.out_data", out_data, 32'd0);
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        row(mk(1'b1, 32'hD1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  3'd1), "post_rst_a");
        row(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  3'd1), "post_rst_b");
        row(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hD1, 3'd1), "post_rst_c");
        row(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hD1, 3'd0), "post_rst_d");
        lat_chk = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef PIPE_STAGE_SKID_EN
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hB1;
        @(posedge clk);
        #1;
        chk("skid.ready_after_b1", 32'(s_in_ready), 32'd1);
        s_in_data = 32'hB2;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        chk("skid.ready_after_b2", 32'(s_in_ready), 32'd0);
        chk("skid.count_full", 32'(s_count), 32'd2);
        chk("skid.head_b1", s_out_data, 32'hB1);
        @(posedge clk);
        #1;
        chk("skid.stall_b1", s_out_data, 32'hB1);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("skid.second_b2", s_out_data, 32'hB2);
        chk("skid.count_one", 32'(s_count), 32'd1);
        chk("skid.ready_back", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("skid.empty_valid", 32'(s_out_valid), 32'd0);
        chk("skid.empty_count", 32'(s_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (M→WB style).
- A chain of DEPTH elastic register stages carries a DATA_W-bit payload bundle (control plus data fields, packed by the instantiator).
- Uses valid/ready handshake, per-stage bubble collapsing, synchronous flush and an occupancy count.
- Sits between any two pipeline stages that need stall/flush capability without hazard logic in the stage itself.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- DEPTH, 1, number of register stages (≥1); zero-stall latency in cycles.
- CNT_W, $clog2(DEPTH+2), width of occupancy count; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- in_valid_i  in  1  upstream has a payload.
- in_data_i  in  DATA_W  upstream payload.
- in_ready_o  out  1  block accepts payload this cycle.
- out_valid_o  out  1  final stage holds a payload.
- out_data_o  out  DATA_W  final-stage payload.
- out_ready_i  in  1  downstream accepts payload this cycle.
- flush_i  in  1  synchronous kill of all held payloads.
- count_o  out  CNT_W  number of valid entries held.

Behaviour:
- State per stage k (0..DEPTH-1): valid_k, data_k. Stage 0 is input side; stage DEPTH-1 drives outputs.
- rst_i asserted (async, any time, including mid-transfer): all valid_k=0, data_k=0. Consequently out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1.
- Ready chain (combinational):
  - rdy_DEPTH = out_ready_i.
  - rdy_k = !valid_k || rdy_(k+1).
  - in_ready_o = rdy_0.
  - Bubbles collapse: an empty stage always accepts, even if downstream is stalled.
- Transfer: input handshake when in_valid_i && in_ready_o; output handshake when out_valid_o && out_ready_i.
- Per clock edge, flush_i=0, for each stage k where rdy_k=1:
  - valid_k <= valid of the source (in_valid_i for k=0, else valid_(k-1)).
  - data_k <= source data, loaded only when source valid=1; otherwise data_k is held.
- Stages with rdy_k=0 hold valid and data unchanged (stall). A stalled payload never changes while out_valid_o=1 and out_ready_i=0.
- Latency: with no stall, a payload accepted at edge N appears on out_* after edge N+DEPTH-1, i.e. DEPTH cycles registered.
- Throughput: 1 payload/cycle when out_ready_i is held high.
- Full: all valid_k=1 and out_ready_i=0 → in_ready_o=0.
- Full with out_ready_i=1: in_ready_o=1 (combinational pass-through of ready). Simultaneous input and output handshakes both complete; count unchanged.
- Flush (flush_i=1 at an edge):
  - All valid_k <= 0; data_k held.
  - An input handshake in the same cycle is dropped.
  - An output handshake in the same cycle still completes (downstream consumed it).
  - in_ready_o is not gated by flush_i.
- flush_i together with rst_i: reset dominates.
- count_o: registered popcount of valid bits; +1 on input handshake, -1 on output handshake, both → no change; flush → 0. Never exceeds DEPTH (DEPTH+1 with skid).
- out_data_o when out_valid_o=0 is don't-care for consumers, but deterministic: last loaded value or 0 after reset.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - Adds a one-entry skid register (skid_valid, skid_data) in front of stage 0.
  - in_ready_o = !skid_valid, a pure flop output with no combinational path from out_ready_i.
  - An accepted payload goes directly into stage 0 when rdy_0=1; otherwise it goes into the skid.
  - The skid drains into stage 0 (priority over new input) when rdy_0=1.
  - Capacity DEPTH+1. Zero-stall latency unchanged (DEPTH).
  - Flush and reset clear skid_valid. count_o includes the skid.
- Undefined: no skid, capacity DEPTH, in_ready_o combinational as above.

Test Plan:
- DATA_W=32, DEPTH=3, out_ready_i=1, push 0xA0000001..0xA0000005 on consecutive cycles → each appears on out_data_o exactly 3 cycles after acceptance, back-to-back, count_o steady at 3.
- DEPTH=3:
  - Push 0x11,0x22 then hold out_ready_i=0 for 5 cycles → out_data_o=0x11 stable.
  - Push 0x33 and 0x44 → 0x33 accepted into the bubble, then in_ready_o=0 at count_o=3.
  - Release out_ready_i → 0x11,0x22,0x33 in order and 0x44 accepted.
- Full pipe (count_o=3), out_ready_i=1, in_valid_i=1 data 0x55 → in_ready_o=1, output handshake and input handshake in the same cycle, count_o stays 3.
- Pipe holding 0x66,0x77, assert flush_i with in_valid_i=1 data 0x88 and out_ready_i=0 → next cycle out_valid_o=0, count_o=0, 0x88 never emerges.
- rst_i pulsed asynchronously between edges while count_o=2 → out_valid_o=0, count_o=0, out_data_o=0 immediately, before the next edge. First push after release emerges after 3 cycles.
- PIPE_STAGE_SKID_EN, DEPTH=1, out_ready_i=0:
  - Push 0xB1,0xB2 → in_ready_o falls the cycle after 0xB2 is accepted, count_o=2.
  - Release out_ready_i → 0xB1 then 0xB2 in order.
